// File: rtl/multi_port_queue_domain_pkg.sv
// multi_port_queue_domain_pkg: shared defaults, width helpers and typedefs for the queue domain
package multi_port_queue_domain_pkg;
    localparam int DEF_PORTS = 2;
    localparam int DEF_QPP = 2;
    localparam int DEF_DATA = 678;
    localparam int DEF_QLEN = 16;
    localparam int DEF_REG = 32;
    localparam int DEF_DROP = 16;
    localparam int DEF_NQ = DEF_PORTS * DEF_QPP;
    typedef logic [DEF_DATA-1:0] packet_t;
    typedef logic [$clog2(DEF_NQ)-1:0] qidx_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int ptr_w(input int qlen);
        return $clog2(qlen);
    endfunction
    function automatic int cnt_w(input int qlen);
        return $clog2(qlen) + 1;
    endfunction
endpackage

// File: rtl/multi_port_queue_domain_queue_channel.sv
// multi_port_queue_domain_queue_channel: one FIFO with status, hysteresis throttle and saturating drop counter
module multi_port_queue_domain_queue_channel
    import multi_port_queue_domain_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA,
    parameter int QUEUE_LENGTH = DEF_QLEN,
    parameter int REGISTER_SIZE = DEF_REG,
    parameter int DROP_COUNT_WIDTH = DEF_DROP
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_SIZE-1:0]        wr_data,
    input  logic                        rd_en,
    input  logic [REGISTER_SIZE-1:0]    high_threshold,
    input  logic [REGISTER_SIZE-1:0]    low_threshold,
    output logic [DATA_SIZE-1:0]        head,
    output logic                        empty,
    output logic                        full,
    output logic                        last_elem,
    output logic [cnt_w(QUEUE_LENGTH)-1:0] occupancy,
    output logic                        kill,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);
    localparam int PW = ptr_w(QUEUE_LENGTH);
    localparam int CW = cnt_w(QUEUE_LENGTH);
    logic [DATA_SIZE-1:0] mem [QUEUE_LENGTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic do_rd, do_wr;
    logic [REGISTER_SIZE-1:0] level;
    // a pop on a full queue frees the slot the simultaneous write lands in
    assign do_rd = rd_en && count != '0;
    assign do_wr = wr_en && (!full || do_rd);
    assign level = REGISTER_SIZE'(count);
    assign empty = count == '0;
    assign full = count == CW'(QUEUE_LENGTH);
    assign last_elem = count == CW'(1);
    assign occupancy = count;
    assign head = mem[rptr];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            kill <= 1'b0;
            drop_count <= '0;
        end else begin
            wptr <= wptr + PW'(do_wr);
            rptr <= rptr + PW'(do_rd);
            count <= count + CW'(do_wr) - CW'(do_rd);
            kill <= high_threshold == '0 ? 1'b0 :
                    level >= high_threshold ? 1'b1 :
                    level <= low_threshold ? 1'b0 : kill;
            if (wr_en && !do_wr && drop_count != '1)
                drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
        end
    end
    always_ff @(posedge clock) begin
        if (do_wr)
            mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/multi_port_queue_domain.sv
// multi_port_queue_domain: steers packetizer ports into per-port queue groups and muxes the scheduler-selected head
module multi_port_queue_domain
    import multi_port_queue_domain_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = DEF_PORTS,
    parameter int QUEUES_PER_PORT = DEF_QPP,
    parameter int DATA_SIZE = DEF_DATA,
    parameter int QUEUE_LENGTH = DEF_QLEN,
    parameter int REGISTER_SIZE = DEF_REG,
    parameter int DROP_COUNT_WIDTH = DEF_DROP,
    localparam int NQ = NUMBER_OF_PORTS * QUEUES_PER_PORT,
    localparam int IW = idx_w(QUEUES_PER_PORT),
    localparam int RW = idx_w(NQ),
    localparam int CW = cnt_w(QUEUE_LENGTH)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUMBER_OF_PORTS-1:0][DATA_SIZE-1:0] in_packet,
    input  logic [NUMBER_OF_PORTS-1:0]                in_valid,
    input  logic [NUMBER_OF_PORTS-1:0][IW-1:0]        in_id,
    input  logic [RW-1:0]                             read_index,
    input  logic                                      read_consume,
    input  logic [NQ-1:0][REGISTER_SIZE-1:0]          high_threshold,
    input  logic [NQ-1:0][REGISTER_SIZE-1:0]          low_threshold,
    output logic [DATA_SIZE-1:0]                      out_packet,
    output logic                                      out_valid,
    output logic [NQ-1:0]                             empty,
    output logic [NQ-1:0]                             full,
    output logic [NQ-1:0]                             last_elem,
    output logic [NQ-1:0][CW-1:0]                     occupancy,
    output logic [NQ-1:0]                             kill_the_core,
    output logic [NQ-1:0][DROP_COUNT_WIDTH-1:0]       drop_count
);
    logic [NQ-1:0][DATA_SIZE-1:0] heads;
    for (genvar p = 0; p < NUMBER_OF_PORTS; p++) begin : g_port
        for (genvar i = 0; i < QUEUES_PER_PORT; i++) begin : g_queue
            localparam int Q = p * QUEUES_PER_PORT + i;
            logic wr_en, rd_en;
            assign wr_en = in_valid[p] && in_id[p] == IW'(i);
            assign rd_en = read_consume && read_index == RW'(Q);
            multi_port_queue_domain_queue_channel #(
                .DATA_SIZE(DATA_SIZE),
                .QUEUE_LENGTH(QUEUE_LENGTH),
                .REGISTER_SIZE(REGISTER_SIZE),
                .DROP_COUNT_WIDTH(DROP_COUNT_WIDTH)
            ) u_channel (
                .clock(clock),
                .reset(reset),
                .wr_en(wr_en),
                .wr_data(in_packet[p]),
                .rd_en(rd_en),
                .high_threshold(high_threshold[Q]),
                .low_threshold(low_threshold[Q]),
                .head(heads[Q]),
                .empty(empty[Q]),
                .full(full[Q]),
                .last_elem(last_elem[Q]),
                .occupancy(occupancy[Q]),
                .kill(kill_the_core[Q]),
                .drop_count(drop_count[Q])
            );
        end
    end
    assign out_packet = heads[read_index];
    assign out_valid = !empty[read_index];
endmodule

// File: tb/tb_multi_port_queue_domain.sv
// tb_multi_port_queue_domain: scoreboard bench for the default and a 3x4x4 wrap-around configuration
module tb_multi_port_queue_domain;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0][677:0] a_pkt;
    logic [1:0] a_val;
    logic [1:0][0:0] a_id;
    logic [1:0] a_ridx;
    logic a_cons;
    logic [3:0][31:0] a_hi, a_lo;
    logic [677:0] a_out;
    logic a_ov;
    logic [3:0] a_empty, a_full, a_last, a_kill;
    logic [3:0][4:0] a_occ;
    logic [3:0][15:0] a_drop;

    logic [2:0][15:0] b_pkt;
    logic [2:0] b_val;
    logic [2:0][1:0] b_id;
    logic [3:0] b_ridx;
    logic b_cons;
    logic [11:0][31:0] b_hi, b_lo;
    logic [15:0] b_out;
    logic b_ov;
    logic [11:0] b_empty, b_full, b_last, b_kill;
    logic [11:0][2:0] b_occ;
    logic [11:0][15:0] b_drop;

    int checks = 0;
    int errors = 0;
    logic [677:0] sb_a [4][$];
    logic [15:0] sb_b [12][$];
    logic [677:0] exp_a;

    multi_port_queue_domain dut_a (
        .clock(clock), .reset(reset),
        .in_packet(a_pkt), .in_valid(a_val), .in_id(a_id),
        .read_index(a_ridx), .read_consume(a_cons),
        .high_threshold(a_hi), .low_threshold(a_lo),
        .out_packet(a_out), .out_valid(a_ov),
        .empty(a_empty), .full(a_full), .last_elem(a_last),
        .occupancy(a_occ), .kill_the_core(a_kill), .drop_count(a_drop)
    );

    multi_port_queue_domain #(
        .NUMBER_OF_PORTS(3), .QUEUES_PER_PORT(4), .DATA_SIZE(16), .QUEUE_LENGTH(4)
    ) dut_b (
        .clock(clock), .reset(reset),
        .in_packet(b_pkt), .in_valid(b_val), .in_id(b_id),
        .read_index(b_ridx), .read_consume(b_cons),
        .high_threshold(b_hi), .low_threshold(b_lo),
        .out_packet(b_out), .out_valid(b_ov),
        .empty(b_empty), .full(b_full), .last_elem(b_last),
        .occupancy(b_occ), .kill_the_core(b_kill), .drop_count(b_drop)
    );

    function automatic logic [677:0] pk(input int n);
        logic [677:0] v;
        v = '0;
        v[31:0] = n;
        v[400:369] = n * 7;
        v[677:646] = ~n;
        return v;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        a_pkt = '0; a_val = '0; a_id = '0; a_ridx = '0; a_cons = 1'b0; a_hi = '0; a_lo = '0;
        b_pkt = '0; b_val = '0; b_id = '0; b_ridx = '0; b_cons = 1'b0; b_hi = '0; b_lo = '0;
        fork
            forever begin
                @(negedge clock);
                if (!reset && a_cons && a_ov) begin
                    if (sb_a[a_ridx].size() == 0) begin
                        chk("a_pop_unexpected", {32'h0, a_out[31:0]}, 64'hdead_0000);
                    end else begin
                        exp_a = sb_a[a_ridx].pop_front();
                        checks++;
                        if (a_out !== exp_a) begin
                            errors++;
                            $display("FAIL a_head q%0d: got %0h expected %0h", a_ridx, a_out[31:0], exp_a[31:0]);
                        end
                    end
                end
                if (!reset && b_cons && b_ov) begin
                    if (sb_b[b_ridx].size() == 0)
                        chk("b_pop_unexpected", {48'h0, b_out}, 64'hdead_0000);
                    else
                        chk("b_head", {48'h0, b_out}, {48'h0, sb_b[b_ridx].pop_front()});
                end
            end
        join_none

        #1 reset = 1'b1;
        #3;
        chk("rst_empty_a", a_empty, 4'hf);
        chk("rst_full_a", a_full, 0);
        chk("rst_kill_a", a_kill, 0);
        chk("rst_occ_a", a_occ, 0);
        chk("rst_drop_a", a_drop, 0);
        chk("rst_empty_b", b_empty, 12'hfff);
        @(negedge clock) reset = 1'b0;
        tick;

        // 1: parallel writes from both ports, then FIFO order on queue 0
        a_id[0] = 1'b0; a_id[1] = 1'b1;
        a_val = 2'b11; a_pkt[0] = pk(1); a_pkt[1] = pk(3);
        sb_a[0].push_back(pk(1)); sb_a[3].push_back(pk(3));
        tick;
        a_val = 2'b01; a_pkt[0] = pk(2); sb_a[0].push_back(pk(2));
        tick;
        a_val = 2'b00;
        chk("t1_occ0", a_occ[0], 2);
        chk("t1_occ3", a_occ[3], 1);
        chk("t1_last3", a_last[3], 1);
        a_ridx = 2'd0; a_cons = 1'b1;
        tick; tick;
        a_cons = 1'b0;
        chk("t1_empty0", a_empty[0], 1);
        a_ridx = 2'd3; a_cons = 1'b1;
        tick;
        a_cons = 1'b0;
        chk("t1_empty3", a_empty[3], 1);

        // 2: fill queue 2, overflow by three, then write+consume while full
        a_id[1] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_val = 2'b10; a_pkt[1] = pk(100 + i); sb_a[2].push_back(pk(100 + i));
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            a_pkt[1] = pk(200 + i);
            tick;
        end
        a_val = 2'b00;
        chk("t2_full", a_full[2], 1);
        chk("t2_drop", a_drop[2], 3);
        chk("t2_occ", a_occ[2], 16);
        a_ridx = 2'd2; a_cons = 1'b1; a_val = 2'b10; a_pkt[1] = pk(300); sb_a[2].push_back(pk(300));
        tick;
        a_val = 2'b00;
        chk("t2_drop_same", a_drop[2], 3);
        chk("t2_occ_same", a_occ[2], 16);
        for (int i = 0; i < 17; i++) tick;
        a_cons = 1'b0;
        chk("t2_empty", a_empty[2], 1);

        // 3: hysteresis on queue 1 (high 8, low 3)
        a_hi[1] = 32'd8; a_lo[1] = 32'd3;
        a_id[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_val = 2'b01; a_pkt[0] = pk(400 + i); sb_a[1].push_back(pk(400 + i));
            tick;
        end
        a_val = 2'b00;
        chk("t3_occ8", a_occ[1], 8);
        chk("t3_kill_lag", a_kill[1], 0);
        tick;
        chk("t3_kill_on", a_kill[1], 1);
        a_ridx = 2'd1; a_cons = 1'b1;
        tick; tick; tick;
        a_cons = 1'b0;
        chk("t3_occ5", a_occ[1], 5);
        tick;
        chk("t3_kill_hold", a_kill[1], 1);
        a_cons = 1'b1;
        tick; tick;
        a_cons = 1'b0;
        chk("t3_occ3", a_occ[1], 3);
        chk("t3_kill_lag_off", a_kill[1], 1);
        tick;
        chk("t3_kill_off", a_kill[1], 0);
        a_cons = 1'b1;
        tick; tick; tick;
        a_cons = 1'b0;
        chk("t3_empty", a_empty[1], 1);

        // 4: consume on empty queue together with a write
        a_id[0] = 1'b0; a_ridx = 2'd0; a_cons = 1'b1;
        a_val = 2'b01; a_pkt[0] = pk(500); sb_a[0].push_back(pk(500));
        tick;
        a_val = 2'b00; a_cons = 1'b0;
        chk("t4_occ", a_occ[0], 1);
        chk("t4_valid", a_ov, 1);
        chk("t4_head", a_out == pk(500), 1);
        a_cons = 1'b1;
        tick;
        a_cons = 1'b0;
        chk("t4_empty", a_empty[0], 1);

        // 5: wrap-around across all 12 queues of the small configuration
        for (int q = 0; q < 12; q++) begin
            b_id[q / 4] = 2'(q % 4);
            b_ridx = 4'(q);
            for (int k = 0; k < 10; k++) begin
                b_val = 3'(1 << (q / 4));
                b_pkt[q / 4] = 16'(q * 16 + k);
                sb_b[q].push_back(16'(q * 16 + k));
                b_cons = k >= 2;
                tick;
                if (k == 1) chk("t5_occ2", b_occ[q], 2);
            end
            b_val = 3'b000; b_cons = 1'b1;
            tick;
            chk("t5_last", b_last[q], 1);
            tick;
            b_cons = 1'b0;
        end
        chk("t5_all_empty", b_empty, 12'hfff);
        chk("t5_no_drop", b_drop, 0);

        // 6: asynchronous reset mid-burst with throttle asserted
        a_id[0] = 1'b1; a_id[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_val = i < 4 ? 2'b11 : 2'b01;
            a_pkt[0] = pk(700 + i); a_pkt[1] = pk(800 + i);
            tick;
        end
        a_val = 2'b00;
        tick;
        chk("t6_kill_pre", a_kill[1], 1);
        chk("t6_occ3_pre", a_occ[3], 4);
        a_val = 2'b01; a_pkt[0] = pk(900); a_ridx = 2'd1;
        #2 reset = 1'b1;
        #1;
        a_val = 2'b00;
        chk("t6_empty", a_empty, 4'hf);
        chk("t6_full", a_full, 0);
        chk("t6_last", a_last, 0);
        chk("t6_occ", a_occ, 0);
        chk("t6_kill", a_kill, 0);
        chk("t6_drop", a_drop, 0);
        chk("t6_valid", a_ov, 0);
        for (int q = 0; q < 4; q++) sb_a[q].delete();
        @(negedge clock) reset = 1'b0;
        tick;
        a_id[0] = 1'b0; a_ridx = 2'd0;
        a_val = 2'b01; a_pkt[0] = pk(600); sb_a[0].push_back(pk(600));
        tick;
        a_val = 2'b00;
        chk("t6_post_occ", a_occ[0], 1);
        a_cons = 1'b1;
        tick;
        a_cons = 1'b0;
        chk("t6_post_empty", a_empty[0], 1);

        for (int q = 0; q < 4; q++) chk("sb_left_a", 64'(sb_a[q].size()), 0);
        for (int q = 0; q < 12; q++) chk("sb_left_b", 64'(sb_b[q].size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
